sva_seq_driver: RTL

SVA_SEQ_DRIVER -- requirements
Module: sva_seq_driver

---
 rtl/sva_seq_driver.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/sva_seq_driver.sv
// sva_seq_driver
//
// Drives a/b stimulus into an "a ##[0:MAX_GAP] b" style checker and
// predicts, with one-cycle exp_succ / exp_fail pulses, the result the
// checker must report for each sequence.
//
// A command (cmd_gap, cmd_drop_b) is accepted in IDLE. The sequence is:
//   - a=1 for one cycle
//   - then either cmd_gap cycles of b=0 followed by one b=1 cycle (pass),
//   - or MAX_GAP+1 cycles of b=0 with b never asserted (fail).
// An optional cool-down of IDLE_GAP cycles with a=b=0 follows.
//
// Optional feature macro: SEQ_DRV_STATS_EN
//   defined   : succ_cnt / fail_cnt count the exp pulses, saturating at all-ones
//   undefined : succ_cnt / fail_cnt read 0 and no counter flops exist
//
// Parameters
//   MAX_GAP   maximum number of !b cycles the checker tolerates between a and b
//   IDLE_GAP  cool-down cycles after each sequence (0..15)
//   CNT_W     width of the statistics counters
//
// Ports
//   gclk        clock, all logic on its rising edge
//   grst_n      asynchronous active-low reset
//   cmd_valid   a command is offered
//   cmd_ready   driver accepts a command (IDLE only)
//   cmd_gap     number of !b cycles to drive after a
//   cmd_drop_b  never drive b; sequence is expected to fail
//   abort       synchronous abort of the current sequence
//   a, b        registered stimulus to the checker
//   busy        registered, high while state != IDLE
//   exp_succ    one-cycle pulse: checker must report success
//   exp_fail    one-cycle pulse: checker must report failure
//   succ_cnt    number of exp_succ pulses
//   fail_cnt    number of exp_fail pulses
//
// State table
//   state    | meaning
//   IDLE     | waiting for a command, cmd_ready=1
//   DRV_A    | a=1 for one cycle, command latched
//   DRV_WAIT | a=b=0, gap counter running
//   DRV_B    | b=1 for one cycle with exp_succ
//   COOL     | a=b=0 cool-down before returning to IDLE

module sva_seq_driver #(
  parameter int MAX_GAP  = 2,
  parameter int IDLE_GAP = 1,
  parameter int CNT_W    = 16
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_gap,
  input  logic             cmd_drop_b,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             exp_succ,
  output logic             exp_fail,
  output logic [CNT_W-1:0] succ_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int CW = $clog2(MAX_GAP + 2);

  // Fail sequences spend MAX_GAP+1 cycles in DRV_WAIT; the down-counter is
  // loaded with one less than the dwell time and terminates at zero.
  localparam logic [CW-1:0] FAIL_LOAD = CW'(MAX_GAP);
  localparam logic [3:0]    COOL_LOAD = 4'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
  localparam logic          FAIL_NOW_AT_LOAD = (MAX_GAP == 0);
  localparam logic          NO_COOL = (IDLE_GAP == 0);

  typedef enum logic [2:0] {
    IDLE,
    DRV_A,
    DRV_WAIT,
    DRV_B,
    COOL
  } state_t;

  state_t          state;
  logic [1:0]      gap_q;
  logic            drop_q;
  logic [CW-1:0]   wait_cnt;
  logic [3:0]      cool_cnt;
  logic            fail_seq;

  // The latched command decides pass/fail for the whole sequence.
  assign fail_seq  = drop_q || (32'(gap_q) > 32'(MAX_GAP));
  assign cmd_ready = (state == IDLE);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state    <= IDLE;
      gap_q    <= '0;
      drop_q   <= 1'b0;
      wait_cnt <= '0;
      cool_cnt <= '0;
      a        <= 1'b0;
      b        <= 1'b0;
      busy     <= 1'b0;
      exp_succ <= 1'b0;
      exp_fail <= 1'b0;
    end else begin
      // Stimulus and pulses are single-cycle unless a branch re-asserts them.
      a        <= 1'b0;
      b        <= 1'b0;
      exp_succ <= 1'b0;
      exp_fail <= 1'b0;

      if (abort) begin
        // Abort wins everywhere, including a handshake in IDLE.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cmd_valid) begin
              gap_q  <= cmd_gap;
              drop_q <= cmd_drop_b;
              state  <= DRV_A;
              a      <= 1'b1;
              busy   <= 1'b1;
            end
          end

          DRV_A: begin
            if (fail_seq) begin
              state    <= DRV_WAIT;
              wait_cnt <= FAIL_LOAD;
              exp_fail <= FAIL_NOW_AT_LOAD;
            end else if (gap_q == 2'd0) begin
              state    <= DRV_B;
              b        <= 1'b1;
              exp_succ <= 1'b1;
            end else begin
              state    <= DRV_WAIT;
              wait_cnt <= CW'(gap_q - 2'd1);
            end
          end

          DRV_WAIT: begin
            if (wait_cnt == '0) begin
              if (fail_seq) begin
                // Last fail cycle just ended; exp_fail was already issued.
                if (NO_COOL) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end else begin
                  state    <= COOL;
                  cool_cnt <= COOL_LOAD;
                end
              end else begin
                state    <= DRV_B;
                b        <= 1'b1;
                exp_succ <= 1'b1;
              end
            end else begin
              wait_cnt <= wait_cnt - CW'(1);
              // exp_fail must coincide with the final b=0 cycle, so it is
              // raised while stepping into the terminal count.
              exp_fail <= fail_seq && (wait_cnt == CW'(1));
            end
          end

          DRV_B: begin
            if (NO_COOL) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= COOL;
              cool_cnt <= COOL_LOAD;
            end
          end

          COOL: begin
            if (cool_cnt == 4'd0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cool_cnt <= cool_cnt - 4'd1;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_DRV_STATS_EN
  logic [CNT_W-1:0] succ_q;
  logic [CNT_W-1:0] fail_q;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      succ_q <= '0;
      fail_q <= '0;
    end else begin
      if (exp_succ && (succ_q != '1)) begin
        succ_q <= succ_q + CNT_W'(1);
      end
      if (exp_fail && (fail_q != '1)) begin
        fail_q <= fail_q + CNT_W'(1);
      end
    end
  end

  assign succ_cnt = succ_q;
  assign fail_cnt = fail_q;
`else
  assign succ_cnt = '0;
  assign fail_cnt = '0;
`endif

endmodule
